ctrl_pipe_dew: RTL and testbench
================================

Name: ctrl_pipe_dew

Overview:
- Carries the decode-stage control word from the main/ALU decoder through the E, M and W pipeline registers of the pipelined RV32I core.
- Applies the hazard unit's stall and flush requests to the control path.
- Resolves the branch/jump redirect in E (PCSrcE).
- Tracks a per-stage valid bit and counts retired instructions.
- Datapath registers (operands, immediates, PCs) live elsewhere; this block owns control only.

Parameters:
RET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
ValidD  in  1  D-stage slot holds a real instruction (0 after FlushD/reset)
RegWriteD  in  1  decoder control
ResultSrcD  in  2  decoder control
MemWriteD  in  1  decoder control
JumpD  in  1  decoder control (JAL)
JumpRegD  in  1  decoder control (JALR)
BranchD  in  1  decoder control
ALUControlD  in  4  decoder control
ALUSrcD  in  1  decoder control
InverseBrCondD  in  1  decoder control; invert Zero test
StallE  in  1  hold E register
FlushE  in  1  bubble into E register
ZeroE  in  1  ALU zero flag for the E instruction
ALUControlE  out  4  to ALU
ALUSrcE  out  1  to SrcB mux
ResultSrcE0  out  1  ResultSrcE[0], load-use detect for hazard unit
RegWriteE  out  1  to hazard unit
PCSrcE  out  1  take redirect
PCTargetSrcE  out  1  1: target from ALU result (JALR), 0: PC+imm
RegWriteM  out  1  M-stage control
ResultSrcM  out  2  M-stage control
MemWriteM  out  1  data-memory write enable
RegWriteW  out  1  W-stage control
ResultSrcW  out  2  W-stage control
ValidE, ValidM, ValidW  out  1 each  stage-valid flags
RetiredCount  out  RET_W  instructions retired

Behaviour:
- Bubble definition: all control fields 0 and Valid 0. An inbound D word with ValidD=0 is converted to a bubble before capture, whatever its other inputs.
- All state updates on rising clk.
- Reset (sync): every E/M/W register is a bubble, RetiredCount=0, all outputs 0. Reset overrides StallE and FlushE.
- E register update priority:
  - reset
  - FlushE: E becomes a bubble. FlushE wins over StallE.
  - StallE: E holds its value.
  - otherwise: E captures the gated D word.
- M register:
  - Captures E every cycle.
  - If StallE=1 and FlushE=0 that cycle, M captures a bubble instead, so the held instruction is not duplicated.
- W register captures M every cycle; never stalls.
- PCSrcE is combinational from E registers: ValidE & (JumpE | JumpRegE | (BranchE & (ZeroE ^ InverseBrCondE))).
- PCTargetSrcE = ValidE & JumpRegE.
- PCSrcE is not masked by StallE. The hazard unit must not assert StallE while a valid control transfer is in E.
- ResultSrcE0 and RegWriteE come straight from E registers. They are 0 for a bubble.
- MemWriteM is 0 whenever ValidM=0. This is guaranteed structurally by the bubble encoding.
- RetiredCount:
  - Increments by 1 on each clock where ValidW=1.
  - Wraps modulo 2^RET_W with no saturation or flag.
  - Reset clears it the same cycle, regardless of ValidW.
- Latency: a D word appears on E outputs 1 cycle after capture, M after 2, W after 3. It is counted as retired on the edge ending its W cycle.
- Reset mid-flight discards all in-flight instructions; none are counted.
- Simultaneous FlushE with PCSrcE=1 (normal taken branch): the redirecting instruction moves to M, and E receives a bubble.

Test Plan:
- Reset held 2 cycles while ValidD=1 with RegWriteD=1, MemWriteD=1 -> all outputs 0, RetiredCount=0; the first instruction appears at E 1 cycle after reset deasserts.
- Stream 4 valid words with RegWriteD=1, ResultSrcD=2'b01, no stall or flush -> each word appears at M 2 cycles and at W 3 cycles after entering D; RetiredCount=4 after drain.
- BranchD=1, InverseBrCondD=0, with ZeroE=1 then ZeroE=0 -> PCSrcE=1 then 0. Repeat with InverseBrCondD=1 (BNE) -> 0 then 1. JumpRegD=1 -> PCSrcE=1 and PCTargetSrcE=1.
- Load in E (ResultSrcE0=1), StallE=1 for one cycle -> E holds, M gets a bubble (ValidM=0, MemWriteM=0), the load reaches M next cycle; no double count in RetiredCount.
- FlushE=1 together with StallE=1 and ValidD=1 -> E becomes a bubble (ValidE=0, PCSrcE=0); ValidD=0 with MemWriteD=1 -> MemWriteM stays 0.
- RET_W=4, retire 17 instructions -> RetiredCount wraps to 1.

Source files
------------

// File: rtl/ctrl_pipe_dew.sv
// Control-word pipeline (E/M/W) for the pipelined RV32I core: stall/flush handling,
// branch/jump redirect resolution in E, per-stage valid tracking and retire counting.
module ctrl_pipe_dew #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             JumpRegD,
    input  logic             BranchD,
    input  logic [3:0]       ALUControlD,
    input  logic             ALUSrcD,
    input  logic             InverseBrCondD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ZeroE,
    output logic [3:0]       ALUControlE,
    output logic             ALUSrcE,
    output logic             ResultSrcE0,
    output logic             RegWriteE,
    output logic             PCSrcE,
    output logic             PCTargetSrcE,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcM,
    output logic             MemWriteM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic             ValidE,
    output logic             ValidM,
    output logic             ValidW,
    output logic [RET_W-1:0] RetiredCount
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jump_reg;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
        logic       inv_br;
    } ctrl_e_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

    ctrl_e_t          d_word;
    ctrl_e_t          e_d, e_q;
    ctrl_m_t          m_d, m_q;
    ctrl_w_t          w_d, w_q;
    logic [RET_W-1:0] ret_d, ret_q;

    // An all-zero word is a bubble, so gating on ValidD makes MemWriteM safe by construction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        d_word = '0;
        if (ValidD) begin
            d_word = '{valid:       1'b1,
                       reg_write:   RegWriteD,
                       result_src:  ResultSrcD,
                       mem_write:   MemWriteD,
                       jump:        JumpD,
                       jump_reg:    JumpRegD,
                       branch:      BranchD,
                       alu_control: ALUControlD,
                       alu_src:     ALUSrcD,
                       inv_br:      InverseBrCondD};
        end
    end

    always_comb begin
        e_d = d_word;
        if (FlushE) begin
            e_d = '0;
        end else if (StallE) begin
            e_d = e_q;
        end
    end

    // While E is held, M takes a bubble so the held instruction is not issued twice.
    always_comb begin
        m_d = '{valid:      e_q.valid,
                reg_write:  e_q.reg_write,
                result_src: e_q.result_src,
                mem_write:  e_q.mem_write};
        if (StallE && !FlushE) begin
            m_d = '0;
        end
    end

    assign w_d   = '{valid: m_q.valid, reg_write: m_q.reg_write, result_src: m_q.result_src};
    assign ret_d = ret_q + {{(RET_W-1){1'b0}}, w_q.valid};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            ret_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            ret_q <= ret_d;
        end
    end

    assign ALUControlE  = e_q.alu_control;
    assign ALUSrcE      = e_q.alu_src;
    assign ResultSrcE0  = e_q.result_src[0];
    assign RegWriteE    = e_q.reg_write;
    assign PCSrcE       = e_q.valid & (e_q.jump | e_q.jump_reg | (e_q.branch & (ZeroE ^ e_q.inv_br)));
    assign PCTargetSrcE = e_q.valid & e_q.jump_reg;
    assign ValidE       = e_q.valid;

    assign RegWriteM    = m_q.reg_write;
    assign ResultSrcM   = m_q.result_src;
    assign MemWriteM    = m_q.mem_write;
    assign ValidM       = m_q.valid;

    assign RegWriteW    = w_q.reg_write;
    assign ResultSrcW   = w_q.result_src;
    assign ValidW       = w_q.valid;

    assign RetiredCount = ret_q;

endmodule

// File: tb/tb_ctrl_pipe_dew.sv
// Bench for ctrl_pipe_dew: directed vectors, W-stage scoreboard plus direct E/M checks,
// and a 4-bit counter instance for the retire-count wrap.
module tb_ctrl_pipe_dew;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidD, RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, InverseBrCondD;
    logic [1:0] ResultSrcD;
    logic [3:0] ALUControlD;
    logic       StallE, FlushE, ZeroE;

    logic [3:0]  ALUControlE;
    logic        ALUSrcE, ResultSrcE0, RegWriteE, PCSrcE, PCTargetSrcE;
    logic        RegWriteM, MemWriteM, RegWriteW, ValidE, ValidM, ValidW;
    logic [1:0]  ResultSrcM, ResultSrcW;
    logic [31:0] RetiredCount;

    logic [3:0]  w4_ALUControlE;
    logic        w4_ALUSrcE, w4_ResultSrcE0, w4_RegWriteE, w4_PCSrcE, w4_PCTargetSrcE;
    logic        w4_RegWriteM, w4_MemWriteM, w4_RegWriteW, w4_ValidE, w4_ValidM, w4_ValidW;
    logic [1:0]  w4_ResultSrcM, w4_ResultSrcW;
    logic [3:0]  w4_RetiredCount;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    ctrl_pipe_dew #(.RET_W(32)) dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .JumpD(JumpD), .JumpRegD(JumpRegD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .InverseBrCondD(InverseBrCondD),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ResultSrcE0(ResultSrcE0), .RegWriteE(RegWriteE),
        .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW), .RetiredCount(RetiredCount)
    );

    ctrl_pipe_dew #(.RET_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .JumpD(JumpD), .JumpRegD(JumpRegD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .InverseBrCondD(InverseBrCondD),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .ALUControlE(w4_ALUControlE), .ALUSrcE(w4_ALUSrcE), .ResultSrcE0(w4_ResultSrcE0),
        .RegWriteE(w4_RegWriteE), .PCSrcE(w4_PCSrcE), .PCTargetSrcE(w4_PCTargetSrcE),
        .RegWriteM(w4_RegWriteM), .ResultSrcM(w4_ResultSrcM), .MemWriteM(w4_MemWriteM),
        .RegWriteW(w4_RegWriteW), .ResultSrcW(w4_ResultSrcW),
        .ValidE(w4_ValidE), .ValidM(w4_ValidM), .ValidW(w4_ValidW), .RetiredCount(w4_RetiredCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Pops one expected W word every time the DUT retires something.
    task automatic monitor();
        logic [2:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && ValidW === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("w_unexpected_retire", 32'(ValidW), 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("w_word", {29'd0, RegWriteW, ResultSrcW}, {29'd0, exp});
                end
            end
        end
    endtask

    task automatic set_d(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic j, input logic jr, input logic br, input logic inv);
        ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw;
        JumpD = j; JumpRegD = jr; BranchD = br; InverseBrCondD = inv;
        ALUControlD = 4'h5; ALUSrcD = 1'b1;
    endtask

    // One clock; a word captured into E is pushed as an expected retirement.
    task automatic step();
        if (!reset && ValidD && !FlushE && !StallE)
            exp_q.push_back({RegWriteD, ResultSrcD});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_d(0, 0, 2'b00, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        fork
            monitor();
        join_none

        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;
        set_d(1, 1, 2'b00, 1, 0, 0, 0, 0);

        // Reset held two cycles with a live store word at D
        step();
        check("rst1_valid_e", 32'(ValidE), 32'd0);
        check("rst1_regwrite_e", 32'(RegWriteE), 32'd0);
        StallE = 1'b1;
        step();
        check("rst2_valid_e", 32'(ValidE), 32'd0);
        check("rst2_memwrite_m", 32'(MemWriteM), 32'd0);
        check("rst2_valid_w", 32'(ValidW), 32'd0);
        check("rst2_retired", RetiredCount, 32'd0);
        check("rst2_pcsrc", 32'(PCSrcE), 32'd0);
        StallE = 1'b0;
        reset = 1'b0;
        step();
        check("post_rst_valid_e", 32'(ValidE), 32'd1);
        check("post_rst_regwrite_e", 32'(RegWriteE), 32'd1);
        check("post_rst_alu_e", 32'(ALUControlE), 32'h5);
        check("post_rst_memwrite_m0", 32'(MemWriteM), 32'd0);
        set_d(0, 0, 2'b00, 0, 0, 0, 0, 0);
        step();
        check("post_rst_memwrite_m1", 32'(MemWriteM), 32'd1);
        step(); step();
        check("retired_after_first", RetiredCount, 32'd1);

        // Four back-to-back writeback words
        set_d(1, 1, 2'b01, 0, 0, 0, 0, 0);
        step();
        check("s_valid_e", 32'(ValidE), 32'd1);
        check("s_valid_m0", 32'(ValidM), 32'd0);
        step();
        check("s_valid_m", 32'(ValidM), 32'd1);
        check("s_resultsrc_m", 32'(ResultSrcM), 32'd1);
        check("s_valid_w0", 32'(ValidW), 32'd0);
        step();
        check("s_valid_w", 32'(ValidW), 32'd1);
        check("s_resultsrc_w", 32'(ResultSrcW), 32'd1);
        step();
        drain();
        check("retired_after_stream", RetiredCount, 32'd5);

        // BEQ, BNE, JALR, JAL, then an invalid word carrying jump bits
        set_d(1, 0, 2'b00, 0, 0, 0, 1, 0);
        step();
        ZeroE = 1'b1; #1;
        check("beq_taken", 32'(PCSrcE), 32'd1);
        ZeroE = 1'b0; #1;
        check("beq_not_taken", 32'(PCSrcE), 32'd0);
        set_d(1, 0, 2'b00, 0, 0, 0, 1, 1);
        step();
        ZeroE = 1'b1; #1;
        check("bne_not_taken", 32'(PCSrcE), 32'd0);
        ZeroE = 1'b0; #1;
        check("bne_taken", 32'(PCSrcE), 32'd1);
        set_d(1, 1, 2'b10, 0, 0, 1, 0, 0);
        step();
        check("jalr_pcsrc", 32'(PCSrcE), 32'd1);
        check("jalr_target", 32'(PCTargetSrcE), 32'd1);
        set_d(1, 1, 2'b10, 0, 1, 0, 0, 0);
        step();
        check("jal_pcsrc", 32'(PCSrcE), 32'd1);
        check("jal_target", 32'(PCTargetSrcE), 32'd0);
        set_d(0, 1, 2'b10, 1, 1, 1, 1, 0);
        step();
        check("bubble_pcsrc", 32'(PCSrcE), 32'd0);
        check("bubble_target", 32'(PCTargetSrcE), 32'd0);
        check("bubble_valid_e", 32'(ValidE), 32'd0);
        drain();
        check("retired_after_branches", RetiredCount, 32'd9);

        // Load-use stall for one cycle
        set_d(1, 1, 2'b01, 0, 0, 0, 0, 0);
        step();
        check("ld_resultsrc_e0", 32'(ResultSrcE0), 32'd1);
        set_d(1, 1, 2'b00, 1, 0, 0, 0, 0);
        StallE = 1'b1;
        step();
        check("stall_hold_valid_e", 32'(ValidE), 32'd1);
        check("stall_hold_resultsrc_e0", 32'(ResultSrcE0), 32'd1);
        check("stall_bubble_valid_m", 32'(ValidM), 32'd0);
        check("stall_bubble_memwrite_m", 32'(MemWriteM), 32'd0);
        StallE = 1'b0;
        step();
        check("ld_valid_m", 32'(ValidM), 32'd1);
        check("ld_resultsrc_m", 32'(ResultSrcM), 32'd1);
        check("st_in_e_resultsrc_e0", 32'(ResultSrcE0), 32'd0);
        drain();
        check("retired_after_stall", RetiredCount, 32'd11);

        // Flush together with stall while a jump sits in E
        set_d(1, 1, 2'b00, 0, 1, 0, 0, 0);
        step();
        check("fl_jump_pcsrc", 32'(PCSrcE), 32'd1);
        set_d(1, 1, 2'b11, 1, 0, 0, 0, 0);
        FlushE = 1'b1; StallE = 1'b1;
        step();
        check("fl_valid_e", 32'(ValidE), 32'd0);
        check("fl_pcsrc", 32'(PCSrcE), 32'd0);
        check("fl_jump_to_m", 32'(ValidM), 32'd1);
        FlushE = 1'b0; StallE = 1'b0;
        set_d(0, 1, 2'b00, 1, 0, 0, 0, 0);
        step();
        check("inv_regwrite_e", 32'(RegWriteE), 32'd0);
        step();
        check("inv_memwrite_m", 32'(MemWriteM), 32'd0);
        check("inv_valid_m", 32'(ValidM), 32'd0);
        drain();
        check("retired_after_flush", RetiredCount, 32'd12);
        check("sb_empty_before_wrap", 32'(exp_q.size()), 32'd0);

        // Seventeen retirements wrap the 4-bit counter to 1
        reset = 1'b1;
        step();
        check("wrap_rst_count32", RetiredCount, 32'd0);
        check("wrap_rst_count4", 32'(w4_RetiredCount), 32'd0);
        reset = 1'b0;
        set_d(1, 1, 2'b00, 0, 0, 0, 0, 0);
        repeat (17) step();
        drain();
        check("wrap_count4", 32'(w4_RetiredCount), 32'd1);
        check("wrap_count32", RetiredCount, 32'd17);
        check("sb_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
